// File: rtl/dm_bus_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
package dm_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    localparam logic [3:0]  BE_FULL      = 4'b1111;
    localparam int unsigned LATENCY_MAX  = 15;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned TRACE_PC_W   = 32;
    localparam int unsigned TRACE_ADDR_W = 32;
    localparam int unsigned TRACE_DATA_W = 32;

    typedef struct packed {
        logic [TRACE_PC_W-1:0]   pc;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] data;
    } trace_rec_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } req_t;

    // Misaligned, or any address bit above the RAM word index is set.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_w);
        logic hi;
        hi = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i >= addr_w + 2 && addr[i]) hi = 1'b1;
        end
        return (addr[1:0] != 2'b00) || hi;
    endfunction

endpackage

// File: rtl/dm_bus_responder_if.sv
// Request, response and write-trace channels of the data-memory responder.
interface dm_bus_responder_if;
    import dm_bus_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic                    trace_valid;
    logic [TRACE_PC_W-1:0]   trace_pc;
    logic [TRACE_ADDR_W-1:0] trace_addr;
    logic [TRACE_DATA_W-1:0] trace_data;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  trace_valid, trace_pc, trace_addr, trace_data
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output trace_valid, trace_pc, trace_addr, trace_data
    );

endinterface

// File: rtl/dm_bus_responder_be_merge.sv
// Byte-lane merge of store data into an existing word.
module be_merge
    import dm_bus_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] new_word_o
);

    always_comb begin
        new_word_o = old_word_i;
        if (be_i == BE_FULL) begin
            new_word_o = wdata_i;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) new_word_o[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_bus_responder.sv
// Single-outstanding load/store responder with programmable wait states, byte
// enables, registered response channel and a one-cycle store trace.
module dm_bus_responder
    import dm_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    dm_bus_responder_if.slave bus
);

    localparam int unsigned      Depth   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CntInit =
        CNT_W'(LATENCY > LATENCY_MAX ? LATENCY_MAX : LATENCY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             trace_valid_q, trace_valid_d;
    trace_rec_t       trace_q, trace_d;

    logic [31:0]       ram_q [Depth];
    req_t              live, cur;
    logic              accept, commit, err, wr_en;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       old_word, merged;

    always_comb begin
        live.we    = bus.req_we;
        live.be    = bus.req_be;
        live.addr  = bus.req_addr;
        live.wdata = bus.req_wdata;
        live.pc    = bus.req_pc;
    end

    assign accept = bus.req_valid & req_ready_q;

    // With no wait states the access commits on the accept edge from the live request.
    assign cur    = (LATENCY == 0) ? live : req_q;
    assign commit = (LATENCY == 0) ? accept : (state_q == StWait && cnt_q == CNT_W'(1));

    assign err      = addr_err(cur.addr, ADDR_W);
    assign idx      = cur.addr[ADDR_W+1:2];
    assign old_word = ram_q[idx];
    assign wr_en    = commit & cur.we & ~err & (cur.be != 4'b0000);

    be_merge u_be_merge (
        .old_word_i (old_word),
        .wdata_i    (cur.wdata),
        .be_i       (cur.be),
        .new_word_o (merged)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_err_d     = rsp_err_q;
        rsp_rdata_d   = rsp_rdata_q;
        trace_valid_d = 1'b0;
        trace_d       = trace_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    req_d       = live;
                    req_ready_d = 1'b0;
                    if (LATENCY == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = StResp;
            end
            StResp: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d     = StIdle;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (commit) begin
            rsp_valid_d   = 1'b1;
            rsp_err_d     = err;
            rsp_rdata_d   = (err || cur.we) ? 32'h0 : old_word;
            trace_valid_d = wr_en;
            trace_d.pc    = cur.pc;
            trace_d.addr  = {cur.addr[31:2], 2'b00};
            trace_d.data  = merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            req_q         <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            trace_valid_q <= 1'b0;
            trace_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
            trace_valid_q <= trace_valid_d;
            trace_q       <= trace_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) ram_q[i] <= '0;
        end else if (wr_en) begin
            ram_q[idx] <= merged;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.trace_valid = trace_valid_q;
    assign bus.trace_pc    = trace_q.pc;
    assign bus.trace_addr  = trace_q.addr;
    assign bus.trace_data  = trace_q.data;

endmodule

// File: tb/tb_dm_bus_responder.sv
// Directed and randomized checks of dm_bus_responder against a word-array memory model.
module tb_dm_bus_responder;

    localparam int unsigned L2 = 2;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    bit [31:0] mem2 [int unsigned];
    bit [31:0] mem0 [int unsigned];

    dm_bus_responder_if b2 ();
    dm_bus_responder_if b0 ();

    dm_bus_responder #(.ADDR_W(12), .LATENCY(L2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    dm_bus_responder #(.ADDR_W(12), .LATENCY(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~m) | (w & m);
    endfunction

    function automatic logic is_err(input logic [31:0] addr);
        return (addr % 4 != 0) || (addr >= 32'h4000);
    endfunction

    function automatic logic [31:0] get2(input logic [31:0] addr);
        int unsigned k;
        k = addr / 4;
        return mem2.exists(k) ? mem2[k] : 32'h0;
    endfunction

    function automatic logic [31:0] get0(input logic [31:0] addr);
        int unsigned k;
        k = addr / 4;
        return mem0.exists(k) ? mem0[k] : 32'h0;
    endfunction

    task automatic txn2(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc, input int hold);
        logic [31:0] old, nw, exp_rd;
        logic        exp_err, exp_tr;
        int          n;
        exp_err = is_err(addr);
        old     = get2(addr);
        nw      = merge(old, wdata, be);
        exp_rd  = (exp_err || we) ? 32'h0 : old;
        exp_tr  = we && !exp_err && be != 4'b0000;
        @(negedge clk);
        chk("req_ready_idle", b2.req_ready, 1);
        b2.req_valid = 1'b1;
        b2.req_we    = we;
        b2.req_be    = be;
        b2.req_addr  = addr;
        b2.req_wdata = wdata;
        b2.req_pc    = pc;
        @(posedge clk);
        @(negedge clk);
        b2.req_valid = 1'b0;
        n = 1;
        while (b2.rsp_valid !== 1'b1 && n < 40) begin
            chk("wait_ready", b2.req_ready, 0);
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", n, L2 + 1);
        if (exp_tr) mem2[addr / 4] = nw;
        chk("rsp_err", b2.rsp_err, exp_err);
        chk("rsp_rdata", b2.rsp_rdata, exp_rd);
        chk("trace_valid", b2.trace_valid, exp_tr);
        if (exp_tr) begin
            chk("trace_pc", b2.trace_pc, pc);
            chk("trace_addr", b2.trace_addr, addr & 32'hFFFF_FFFC);
            chk("trace_data", b2.trace_data, nw);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", b2.rsp_valid, 1);
            chk("hold_rdata", b2.rsp_rdata, exp_rd);
            chk("hold_err", b2.rsp_err, exp_err);
            chk("hold_req_ready", b2.req_ready, 0);
            chk("trace_one_cycle", b2.trace_valid, 0);
        end
        b2.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b2.rsp_ready = 1'b0;
        chk("post_req_ready", b2.req_ready, 1);
        chk("post_rsp_valid", b2.rsp_valid, 0);
    endtask

    logic [31:0] a, w;
    logic [3:0]  be;
    logic        we, e, seen;
    int          last;

    initial begin
        rst = 1'b0;
        b2.req_valid = 0; b2.req_we = 0; b2.req_be = 0; b2.req_addr = 0;
        b2.req_wdata = 0; b2.req_pc = 0; b2.rsp_ready = 0;
        b0.req_valid = 0; b0.req_we = 0; b0.req_be = 0; b0.req_addr = 0;
        b0.req_wdata = 0; b0.req_pc = 0; b0.rsp_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", b2.req_ready, 1);
        chk("rst_rsp_valid", b2.rsp_valid, 0);
        chk("rst_rsp_rdata", b2.rsp_rdata, 0);
        chk("rst_rsp_err", b2.rsp_err, 0);
        chk("rst_trace_valid", b2.trace_valid, 0);
        chk("rst0_req_ready", b0.req_ready, 1);
        rst = 1'b1;

        // Directed sequence
        txn2(1, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h3004, 0);
        txn2(0, 4'b1111, 32'h10, 32'h0, 32'h3008, 0);
        chk("raw_full_model", get2(32'h10), 32'hDEADBEEF);
        txn2(1, 4'b0100, 32'h10, 32'h00AA0000, 32'h300C, 0);
        chk("merge_model", get2(32'h10), 32'hDEAABEEF);
        txn2(0, 4'b1111, 32'h10, 32'h0, 32'h3010, 0);
        txn2(0, 4'b1111, 32'h12, 32'h0, 32'h3014, 0);
        txn2(0, 4'b1111, 32'h4000, 32'h0, 32'h3018, 0);
        txn2(1, 4'b1111, 32'h0, 32'h12345678, 32'h301C, 0);
        txn2(1, 4'b1111, 32'h4000, 32'hCAFEF00D, 32'h3020, 0);
        txn2(0, 4'b1111, 32'h0, 32'h0, 32'h3024, 0);
        txn2(1, 4'b0000, 32'h0, 32'hFFFFFFFF, 32'h3028, 0);
        txn2(0, 4'b0000, 32'h0, 32'h0, 32'h302C, 5);

        // Randomized traffic over a few words, with occasional bad addresses
        for (int k = 0; k < 24; k++) begin
            we = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            a  = 32'($urandom_range(0, 7)) * 4;
            case ($urandom_range(0, 9))
                0: a = a | 32'($urandom_range(1, 3));
                1: a = a | 32'h0001_0000;
                default: ;
            endcase
            w = $urandom;
            txn2(we, be, a, w, 32'h4000 + 32'(k) * 4, $urandom_range(0, 2));
        end

        // Zero wait states: back-to-back transactions every two cycles
        b0.rsp_ready = 1'b1;
        last = 0;
        for (int k = 0; k < 10; k++) begin
            we = (k < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            be = 4'($urandom_range(1, 15));
            a  = 32'(k % 3) * 4;
            w  = $urandom;
            e  = is_err(a);
            @(negedge clk);
            chk("l0_req_ready", b0.req_ready, 1);
            b0.req_valid = 1'b1;
            b0.req_we    = we;
            b0.req_be    = be;
            b0.req_addr  = a;
            b0.req_wdata = w;
            b0.req_pc    = 32'h5000 + 32'(k);
            @(posedge clk);
            @(negedge clk);
            b0.req_valid = 1'b0;
            chk("l0_rsp_valid", b0.rsp_valid, 1);
            chk("l0_rsp_rdata", b0.rsp_rdata, we ? 32'h0 : get0(a));
            chk("l0_trace_valid", b0.trace_valid, we && !e);
            if (we) begin
                mem0[a / 4] = merge(get0(a), w, be);
                chk("l0_trace_data", b0.trace_data, mem0[a / 4]);
            end
            if (k > 0) chk("l0_period", cyc - last, 2);
            last = cyc;
        end
        @(negedge clk);
        b0.rsp_ready = 1'b0;

        // Reset during the wait states drops the store
        @(negedge clk);
        b2.req_valid = 1'b1;
        b2.req_we    = 1'b1;
        b2.req_be    = 4'b1111;
        b2.req_addr  = 32'h20;
        b2.req_wdata = 32'hA5A5A5A5;
        b2.req_pc    = 32'h6000;
        @(posedge clk);
        @(negedge clk);
        b2.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_req_ready", b2.req_ready, 1);
        chk("arst_rsp_valid", b2.rsp_valid, 0);
        mem2.delete();
        mem0.delete();
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b2.rsp_valid !== 1'b0 || b2.trace_valid !== 1'b0) seen = 1'b1;
        end
        chk("arst_no_rsp_or_trace", seen, 0);
        txn2(0, 4'b1111, 32'h20, 32'h0, 32'h6004, 0);
        txn2(0, 4'b1111, 32'h10, 32'h0, 32'h6008, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
